// File: rtl/btn_debounce_3ch.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_3ch
//  Brief    : Three-channel synchroniser + debouncer feeding the (a|b)&c
//             logic stage. Produces clean levels, one-cycle rise/fall
//             strobes, per-channel busy flags and a saturating glitch count.
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce_3ch #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_COUNT    = 20,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] raw_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] rise,
    output logic [2:0] fall,
    output logic [2:0] busy,
    output logic [7:0] glitch_cnt
);

    // Terminal count of the stability counter: reaching it accepts the level.
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DB_COUNT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    logic [2:0] w_level;
    logic [2:0] w_rise;
    logic [2:0] w_fall;
    logic [2:0] w_busy;
    logic [2:0] w_abort;

    // ------------------------------------------------------------------------
    // Per-channel synchroniser and debounce FSM (three identical copies)
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic                   r_level;
        logic                   w_level_nxt;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_busy;
        logic                   w_rise_nxt;
        logic                   w_fall_nxt;
        logic                   w_abort_i;

        // Flop chain: raw input goes straight into the first flop, no logic ahead of it.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in[i]};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

        // Next-state logic: require DB_COUNT consecutive differing samples.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_rise_nxt  = 1'b0;
            w_fall_nxt  = 1'b0;
            w_abort_i   = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_s != r_level) begin
                        w_state_nxt = ST_CHECK;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (w_s == r_level) begin
                        // Input bounced back before becoming stable.
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_abort_i   = 1'b1;
                    end else if (r_cnt == c_cnt_max) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = w_s;
                        w_rise_nxt  = w_s;
                        w_fall_nxt  = ~w_s;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // State, level, strobe and busy registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
                r_busy  <= (w_state_nxt == ST_CHECK);
            end
        end

        assign w_level[i] = r_level;
        assign w_rise[i]  = r_rise;
        assign w_fall[i]  = r_fall;
        assign w_busy[i]  = r_busy;
        assign w_abort[i] = w_abort_i;
    end

    // ------------------------------------------------------------------------
    // Glitch counter: adds the number of channels aborting this cycle
    // ------------------------------------------------------------------------
    logic [7:0] r_glitch;
    logic [1:0] w_abort_sum;
    logic [8:0] w_glitch_sum;

    assign w_abort_sum  = {1'b0, w_abort[0]} + {1'b0, w_abort[1]} + {1'b0, w_abort[2]};
    assign w_glitch_sum = {1'b0, r_glitch} + {7'd0, w_abort_sum};

    // Saturate at 255 rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch <= 8'd0;
        end else begin
            r_glitch <= w_glitch_sum[8] ? 8'hFF : w_glitch_sum[7:0];
        end
    end

    assign a          = w_level[0];
    assign b          = w_level[1];
    assign c          = w_level[2];
    assign rise       = w_rise;
    assign fall       = w_fall;
    assign busy       = w_busy;
    assign glitch_cnt = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_3ch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_debounce_3ch
//  Brief    : Directed self-checking bench for btn_debounce_3ch.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_btn_debounce_3ch;

    logic       clk;
    logic       rst;
    logic [2:0] raw_in;
    logic       a;
    logic       b;
    logic       c;
    logic [2:0] rise;
    logic [2:0] fall;
    logic [2:0] busy;
    logic [7:0] glitch_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    btn_debounce_3ch #(
        .SYNC_STAGES(2),
        .DB_COUNT   (20),
        .CNT_W      (5)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .a         (a),
        .b         (b),
        .c         (c),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: return 1ns after the rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [2:0] v);
        rst    = 1'b1;
        raw_in = v;
        repeat (2) tick();
        rst    = 1'b0;
    endtask

    initial begin
        int   rcount;
        int   redge;
        int   changes;
        int   delta;
        logic [7:0] prev;
        logic [2:0] seen;

        rst    = 1'b1;
        raw_in = 3'b111;

        // Reset held with all inputs high: everything stays cleared.
        repeat (3) tick();
        check("rst_levels", {29'd0, c, b, a}, 32'd0);
        check("rst_rise", {29'd0, rise}, 32'd0);
        check("rst_busy", {29'd0, busy}, 32'd0);
        check("rst_glitch", {24'd0, glitch_cnt}, 32'd0);

        // Release: strobe lands on edge 21 counting the first free edge as 0.
        rst = 1'b0;
        for (int n = 0; n <= 21; n++) begin
            tick();
            check($sformatf("t1_rise_e%0d", n), {29'd0, rise}, (n == 21) ? 32'd7 : 32'd0);
        end
        tick();
        check("t1_levels", {29'd0, c, b, a}, 32'd7);
        check("t1_rise_done", {29'd0, rise}, 32'd0);

        // Drop all inputs: fall strobe with the same latency, rise never with it.
        raw_in = 3'b000;
        for (int n = 0; n <= 21; n++) begin
            tick();
            check($sformatf("t1_fall_e%0d", n), {29'd0, fall}, (n == 21) ? 32'd7 : 32'd0);
        end
        check("t1_nofallrise", {29'd0, rise}, 32'd0);
        tick();
        check("t1_levels_low", {29'd0, c, b, a}, 32'd0);

        // 10-cycle pulse on channel 0: aborted, one glitch.
        do_reset(3'b000);
        repeat (3) tick();
        raw_in = 3'b001;
        repeat (5) tick();
        check("t2_busy", {29'd0, busy}, 32'd1);
        repeat (5) tick();
        raw_in = 3'b000;
        seen   = 3'b000;
        for (int n = 0; n < 10; n++) begin
            tick();
            seen |= rise;
        end
        check("t2_a", {31'd0, a}, 32'd0);
        check("t2_rise", {29'd0, seen}, 32'd0);
        check("t2_glitch", {24'd0, glitch_cnt}, 32'd1);
        check("t2_busy_clr", {29'd0, busy}, 32'd0);

        // Channel 1 bounces every 3 cycles for 60 cycles, then holds high.
        do_reset(3'b000);
        repeat (3) tick();
        rcount = 0;
        redge  = -1;
        for (int ph = 0; ph < 20; ph++) begin
            raw_in = (ph % 2 == 0) ? 3'b010 : 3'b000;
            repeat (3) begin
                tick();
                if (rise[1]) rcount++;
            end
        end
        raw_in = 3'b010;
        for (int n = 0; n < 26; n++) begin
            tick();
            if (rise[1]) begin
                rcount++;
                redge = n;
            end
        end
        check("t3_rise_count", rcount, 32'd1);
        check("t3_rise_edge", redge, 32'd21);
        check("t3_b", {31'd0, b}, 32'd1);
        check("t3_glitch", {24'd0, glitch_cnt}, 32'd10);

        // Simultaneous 5-cycle glitch on all channels: +3 on one edge.
        do_reset(3'b000);
        repeat (3) tick();
        prev    = glitch_cnt;
        changes = 0;
        delta   = 0;
        raw_in  = 3'b111;
        for (int n = 0; n < 15; n++) begin
            if (n == 5) raw_in = 3'b000;
            tick();
            if (glitch_cnt != prev) begin
                changes++;
                delta = int'(glitch_cnt) - int'(prev);
            end
            prev = glitch_cnt;
        end
        check("t4_changes", changes, 32'd1);
        check("t4_delta", delta, 32'd3);
        check("t4_glitch", {24'd0, glitch_cnt}, 32'd3);

        // 100 more triple glitches: counter saturates at 255.
        for (int k = 0; k < 100; k++) begin
            raw_in = 3'b111;
            repeat (5) tick();
            raw_in = 3'b000;
            repeat (5) tick();
            if (k == 50) check("t5_mid", {24'd0, glitch_cnt}, 32'd156);
        end
        check("t5_sat", {24'd0, glitch_cnt}, 32'd255);

        // Reset in the middle of a falling CHECK on channel 0 (cnt = 12).
        do_reset(3'b111);
        repeat (25) tick();
        check("t6_a_high", {31'd0, a}, 32'd1);
        raw_in = 3'b110;
        repeat (14) tick();
        check("t6_busy_mid", {31'd0, busy[0]}, 32'd1);
        check("t6_a_mid", {31'd0, a}, 32'd1);
        rst = 1'b1;
        tick();
        check("t6_a", {31'd0, a}, 32'd0);
        check("t6_busy", {29'd0, busy}, 32'd0);
        check("t6_fall", {29'd0, fall}, 32'd0);
        check("t6_glitch", {24'd0, glitch_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
